// File: rtl/vga_timing_ctrl.sv
// VGA raster timing master: scan counters, registered sync/blank/RGB pins,
// and a once-per-frame tick at the start of vertical blanking.
module vga_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iPIX_EN,
  input  logic        iVGA_R,
  input  logic        iVGA_G,
  input  logic        iVGA_B,
  output logic [10:0] oVGA_X,
  output logic [9:0]  oVGA_Y,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        oVGA_BLANK_n,
  output logic        oVGA_R,
  output logic        oVGA_G,
  output logic        oVGA_B,
  output logic        oFRAME_TICK
);

  localparam logic [10:0] H_LAST       = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] H_ACT        = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST       = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  V_ACT        = 10'(V_ACTIVE);
  localparam logic [9:0]  V_ACT_LAST   = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        SYNC_ACT     = (SYNC_POL != 0);

  logic [10:0] h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        blank_n_q, blank_n_d;
  logic        r_q, r_d, g_q, g_d, b_q, b_d;
  logic        frame_tick_q, frame_tick_d;
  logic        active, h_in_sync, v_in_sync;

  // Decode the current counter position into active/sync windows and X/Y.
  always_comb begin
    active    = (h_q < H_ACT) && (v_q < V_ACT);
    h_in_sync = (h_q >= H_SYNC_START) && (h_q < H_SYNC_END);
    v_in_sync = (v_q >= V_SYNC_START) && (v_q < V_SYNC_END);
    oVGA_X    = active ? h_q : '0;
    oVGA_Y    = active ? v_q : '0;
  end

  // Next-state: advance counters and capture pin values only on pixel ticks.
  always_comb begin
    h_d          = h_q;
    v_d          = v_q;
    hs_d         = hs_q;
    vs_d         = vs_q;
    blank_n_d    = blank_n_q;
    r_d          = r_q;
    g_d          = g_q;
    b_d          = b_q;
    frame_tick_d = 1'b0;
    if (iPIX_EN) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 11'd1;
      end
      hs_d         = h_in_sync ? SYNC_ACT : ~SYNC_ACT;
      vs_d         = v_in_sync ? SYNC_ACT : ~SYNC_ACT;
      blank_n_d    = active;
      r_d          = iVGA_R & active;
      g_d          = iVGA_G & active;
      b_d          = iVGA_B & active;
      // The tick leaves the counters at (0, V_ACTIVE): first blanking line.
      frame_tick_d = (h_q == H_LAST) && (v_q == V_ACT_LAST);
    end
  end

  // State and pin registers with synchronous active-low reset.
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      h_q          <= '0;
      v_q          <= '0;
      hs_q         <= ~SYNC_ACT;
      vs_q         <= ~SYNC_ACT;
      blank_n_q    <= 1'b0;
      r_q          <= 1'b0;
      g_q          <= 1'b0;
      b_q          <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      h_q          <= h_d;
      v_q          <= v_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      blank_n_q    <= blank_n_d;
      r_q          <= r_d;
      g_q          <= g_d;
      b_q          <= b_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign oVGA_HS      = hs_q;
  assign oVGA_VS      = vs_q;
  assign oVGA_BLANK_n = blank_n_q;
  assign oVGA_R       = r_q;
  assign oVGA_G       = g_q;
  assign oVGA_B       = b_q;
  assign oFRAME_TICK  = frame_tick_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Testbench for vga_timing_ctrl: a reduced-geometry instance for whole-frame
// behaviour plus a default-geometry instance for the full-size line timing.
module tb_vga_timing_ctrl;

  // Reduced geometry: line = 4+1+2+1 = 8 ticks, frame = 3+1+1+1 = 6 lines.
  localparam int SHA = 4, SHF = 1, SHS = 2, SHB = 1;
  localparam int SVA = 3, SVF = 1, SVS = 1, SVB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, pix_en = 1'b0, b_in = 1'b0;

  logic [10:0] sx, bx;
  logic [9:0]  sy, by;
  logic s_hs, s_vs, s_bl, s_r, s_g, s_b, s_ft, s_r_in;
  logic b_hs, b_vs, b_bl, b_r, b_g, b_b, b_ft, b_r_in;

  // Colour generators: a one-pixel ball (small) and one column (default).
  assign s_r_in = (sx == 11'd2) && (sy == 10'd1);
  assign b_r_in = (bx == 11'd320);

  vga_timing_ctrl #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .SYNC_POL(0)
  ) u_small (
    .iCLK(clk), .iRST_n(rst_n), .iPIX_EN(pix_en),
    .iVGA_R(s_r_in), .iVGA_G(1'b1), .iVGA_B(b_in),
    .oVGA_X(sx), .oVGA_Y(sy), .oVGA_HS(s_hs), .oVGA_VS(s_vs),
    .oVGA_BLANK_n(s_bl), .oVGA_R(s_r), .oVGA_G(s_g), .oVGA_B(s_b),
    .oFRAME_TICK(s_ft)
  );

  vga_timing_ctrl u_big (
    .iCLK(clk), .iRST_n(rst_n), .iPIX_EN(pix_en),
    .iVGA_R(b_r_in), .iVGA_G(1'b1), .iVGA_B(b_in),
    .oVGA_X(bx), .oVGA_Y(by), .oVGA_HS(b_hs), .oVGA_VS(b_vs),
    .oVGA_BLANK_n(b_bl), .oVGA_R(b_r), .oVGA_G(b_g), .oVGA_B(b_b),
    .oFRAME_TICK(b_ft)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: enabled ticks since reset, and the B value captured last.
  int k = 0;
  bit stepped = 0;
  bit last_b = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tick %0d)", name, act, exp, k);
    end
  endtask

  // Expected outputs derived from the tick count: counters sit at position k,
  // pins show position k-1 (or reset values when k == 0).
  task automatic check_model(input string tag,
                             input int ha, input int hf, input int hsw, input int hb,
                             input int va, input int vf, input int vsw, input int vb,
                             input int ball_h, input int ball_v,
                             input logic [10:0] x, input logic [9:0] y,
                             input logic hs_o, input logic vs_o, input logic bl_o,
                             input logic r_o, input logic g_o, input logic b_o,
                             input logic ft_o);
    int ht, vt, h, v, ph, pv;
    bit act, pact, e_hs, e_vs, e_r;
    ht  = ha + hf + hsw + hb;
    vt  = va + vf + vsw + vb;
    h   = k % ht;
    v   = (k / ht) % vt;
    act = (h < ha) && (v < va);
    chk({tag, ".x"}, 32'(x), act ? h : 0);
    chk({tag, ".y"}, 32'(y), act ? v : 0);
    if (k == 0) begin
      pact = 0; e_hs = 1; e_vs = 1; e_r = 0;
    end else begin
      ph   = (k - 1) % ht;
      pv   = ((k - 1) / ht) % vt;
      pact = (ph < ha) && (pv < va);
      e_hs = !((ph >= ha + hf) && (ph < ha + hf + hsw));
      e_vs = !((pv >= va + vf) && (pv < va + vf + vsw));
      e_r  = pact && (ph == ball_h) && ((ball_v < 0) || (pv == ball_v));
    end
    chk({tag, ".hs"}, 32'(hs_o), 32'(e_hs));
    chk({tag, ".vs"}, 32'(vs_o), 32'(e_vs));
    chk({tag, ".blank_n"}, 32'(bl_o), 32'(pact));
    chk({tag, ".r"}, 32'(r_o), 32'(e_r));
    chk({tag, ".g"}, 32'(g_o), 32'(pact));
    chk({tag, ".b"}, 32'(b_o), 32'(pact && last_b));
    chk({tag, ".frame_tick"}, 32'(ft_o), 32'(stepped && h == 0 && v == va));
  endtask

  // One iCLK cycle: drive on the falling edge, sample 1 time unit after rising.
  task automatic step(input logic rst, input logic en);
    @(negedge clk);
    rst_n  = rst;
    pix_en = en;
    b_in   = 1'($urandom_range(1, 0));
    @(posedge clk);
    #1;
    if (!rst) begin
      k = 0; stepped = 0; last_b = 0;
    end else if (en) begin
      k++; stepped = 1; last_b = b_in;
    end else begin
      stepped = 0;
    end
    check_model("small", SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 2, 1,
                sx, sy, s_hs, s_vs, s_bl, s_r, s_g, s_b, s_ft);
    check_model("big", 640, 16, 96, 48, 480, 10, 2, 33, 320, -1,
                bx, by, b_hs, b_vs, b_bl, b_r, b_g, b_b, b_ft);
  endtask

  typedef struct {
    logic rst_n;
    logic en;
    int   x;
    int   y;
    logic hs;
    logic blank_n;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int ft_cnt, g_cnt, max_x, ticks, hs_low, first_low;
    bit seen;

    // Hand-computed start of line 0 on the reduced geometry, with holds/resets.
    tbl[0]  = '{1'b0, 1'b1, 0, 0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1, 0, 1'b1, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 1, 0, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 2, 0, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 3, 0, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 0, 0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 0, 0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 0, 1, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1, 1, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 0, 0, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 1, 0, 1'b1, 1'b1};

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst_n, tbl[i].en);
      chk($sformatf("vec%0d.x", i), 32'(sx), tbl[i].x);
      chk($sformatf("vec%0d.y", i), 32'(sy), tbl[i].y);
      chk($sformatf("vec%0d.hs", i), 32'(s_hs), 32'(tbl[i].hs));
      chk($sformatf("vec%0d.blank_n", i), 32'(s_bl), 32'(tbl[i].blank_n));
    end

    // Three full-rate frames: one frame tick and 12 lit pixels per frame.
    step(1'b0, 1'b1);
    ft_cnt = 0; g_cnt = 0; max_x = 0;
    for (int i = 0; i < 144; i++) begin
      step(1'b1, 1'b1);
      if (s_ft) ft_cnt++;
      if (s_g) g_cnt++;
      if (32'(sx) > max_x) max_x = 32'(sx);
    end
    chk("full_rate.frame_ticks", ft_cnt, 3);
    chk("full_rate.lit_pixels", g_cnt, 36);
    chk("full_rate.max_x", max_x, SHA - 1);

    // Half-rate pixel enable over two frames: tick still one iCLK wide.
    ft_cnt = 0;
    for (int i = 0; i < 192; i++) begin
      step(1'b1, 1'((i + 1) % 2));
      if (s_ft) ft_cnt++;
    end
    chk("half_rate.frame_ticks", ft_cnt, 2);

    // Mid-frame reset at (3,2), then the next frame tick is 3 lines later.
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if ((k % 8 == 3) && ((k / 8) % 6 == 2)) seen = 1;
      else step(1'b1, 1'b1);
    end
    chk("midreset.reached", 32'(seen), 1);
    step(1'b0, 1'b1);
    chk("midreset.blank_n", 32'(s_bl), 0);
    ticks = 0; seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step(1'b1, 1'b1);
      ticks++;
      if (i == 0) chk("midreset.first_pixel_blank_n", 32'(s_bl), 1);
      if (s_ft) seen = 1;
    end
    chk("midreset.tick_seen", 32'(seen), 1);
    chk("midreset.ticks_to_frame", ticks, SVA * 8);

    // Default geometry: HS active for ticks 656..751, pins one tick later.
    step(1'b0, 1'b1);
    hs_low = 0; first_low = -1;
    for (int i = 1; i <= 1700; i++) begin
      step(1'b1, 1'b1);
      if (i <= 800 && !b_hs) begin
        hs_low++;
        if (first_low < 0) first_low = i;
      end
    end
    chk("big.hs_width", hs_low, 96);
    chk("big.hs_first_pin_tick", first_low, 657);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
